// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared definitions for the common-data-bus scheduler:
//   cdb_src_e  - identifies which producer owns a broadcast (RS or SLB)
//   entry_w()  - width of one queued CDB entry {tag, value, jump, topc}
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

   typedef enum logic {
      SRC_RS  = 1'b0,
      SRC_SLB = 1'b1
   } cdb_src_e;

   function automatic int entry_w(input int tag_w, input int data_w);
      return tag_w + 2 * data_w + 1;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fifo
// Small synchronous FIFO holding completed results for one CDB source.
// The head entry is presented combinationally so the arbiter can broadcast it
// in the same cycle it is popped.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, wdata     write one entry (caller guarantees not full)
//   pop             drop the head entry (caller guarantees not empty)
//   flush           empty the FIFO; takes priority over push/pop
//   rdata           current head entry
//   empty, count    occupancy status
// -----------------------------------------------------------------------------
module cdb_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // NOTE: the storage array has no reset; an entry is only meaningful while
   // count covers it, so clearing it would just cost reset fan-out.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign rdata = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Common-data-bus scheduler. The reservation station (ALU results) and the
// store/load buffer (load results) each push into their own FIFO; one head
// per cycle is granted round-robin and broadcast on a registered CDB.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rdy                 global enable, 0 freezes all state
//   clear               misprediction flush (ignored while rdy=0)
//   alu_*               RS result push interface (valid/ready handshake)
//   slb_*               load result push interface (valid/ready handshake)
//   cdb_*               registered broadcast; cdb_src 0 = RS, 1 = SLB
// -----------------------------------------------------------------------------
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clear,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [TAG_W-1:0]  alu_tag,
   input  logic [DATA_W-1:0] alu_value,
   input  logic              alu_jump,
   input  logic [DATA_W-1:0] alu_topc,
   input  logic              slb_valid,
   output logic              slb_ready,
   input  logic [TAG_W-1:0]  slb_tag,
   input  logic [DATA_W-1:0] slb_value,
   output logic              cdb_valid,
   output logic [TAG_W-1:0]  cdb_tag,
   output logic [DATA_W-1:0] cdb_value,
   output logic              cdb_jump,
   output logic [DATA_W-1:0] cdb_topc,
   output logic              cdb_src
);

   localparam int ENTRY_W = entry_w(TAG_W, DATA_W);
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   logic [ENTRY_W-1:0] alu_head;
   logic [ENTRY_W-1:0] slb_head;
   logic [ENTRY_W-1:0] grant_head;
   logic               alu_empty;
   logic               slb_empty;
   logic [CNT_W-1:0]   alu_count;
   logic [CNT_W-1:0]   slb_count;
   logic               alu_push;
   logic               slb_push;
   logic               alu_pop;
   logic               slb_pop;
   logic               flush;
   logic               grant;
   cdb_src_e           grant_src;
   cdb_src_e           last_src;

   logic [TAG_W-1:0]   head_tag;
   logic [DATA_W-1:0]  head_value;
   logic               head_jump;
   logic [DATA_W-1:0]  head_topc;

   // Ready looks only at current occupancy; a pop in the same cycle does not
   // free a slot early, which keeps ready off the grant logic.
   assign alu_ready = rdy & ~clear & (alu_count < CNT_W'(DEPTH));
   assign slb_ready = rdy & ~clear & (slb_count < CNT_W'(DEPTH));
   assign alu_push  = alu_valid & alu_ready;
   assign slb_push  = slb_valid & slb_ready;
   assign flush     = rdy & clear;

   cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_alu_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (alu_push),
      .pop   (alu_pop),
      .flush (flush),
      .wdata ({alu_tag, alu_value, alu_jump, alu_topc}),
      .rdata (alu_head),
      .empty (alu_empty),
      .count (alu_count)
   );

   // Load results never carry a jump target.
   cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_slb_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (slb_push),
      .pop   (slb_pop),
      .flush (flush),
      .wdata ({slb_tag, slb_value, 1'b0, {DATA_W{1'b0}}}),
      .rdata (slb_head),
      .empty (slb_empty),
      .count (slb_count)
   );

   // NOTE: every output of this combinational block gets a default first so
   // no path through the if/else leaves a value unassigned (no latches).
   always_comb begin
      grant     = 1'b0;
      grant_src = SRC_RS;
      if (rdy && !clear) begin
         if (!alu_empty && !slb_empty) begin
            // Contention: the source that did not win last time goes now.
            grant     = 1'b1;
            grant_src = (last_src == SRC_RS) ? SRC_SLB : SRC_RS;
         end else if (!alu_empty) begin
            grant     = 1'b1;
            grant_src = SRC_RS;
         end else if (!slb_empty) begin
            grant     = 1'b1;
            grant_src = SRC_SLB;
         end
      end
   end

   assign alu_pop    = grant & (grant_src == SRC_RS);
   assign slb_pop    = grant & (grant_src == SRC_SLB);
   assign grant_head = (grant_src == SRC_SLB) ? slb_head : alu_head;
   assign {head_tag, head_value, head_jump, head_topc} = grant_head;

   // Output register. rdy=0 holds everything; clear suppresses the grant
   // above, so it falls into the idle branch and the bus goes quiet.
   // last_src resets to SLB so the RS wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_jump  <= 1'b0;
         cdb_topc  <= '0;
         cdb_src   <= 1'b0;
         last_src  <= SRC_SLB;
      end else if (rdy) begin
         if (grant) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= head_tag;
            cdb_value <= head_value;
            cdb_jump  <= head_jump;
            cdb_topc  <= head_jump ? head_topc : '0;
            cdb_src   <= grant_src;
            last_src  <= grant_src;
         end else begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_jump  <= 1'b0;
            cdb_topc  <= '0;
            cdb_src   <= 1'b0;
         end
      end
   end

endmodule
